ram_arbiter: RTL
================

# ram_arbiter

Sequencer and two-way arbiter that shares the single-port RAM between the SPI slave command stream and a local parallel host port. It decodes the 10-bit SPI command words (address-latch and access commands) and holds address registers for them. Both requesters' accesses are scheduled onto one registered RAM port with round-robin fairness, and read data returns to whichever requester issued the read. The block sits between the SPI slave (rx_data/rx_valid, tx_data/tx_valid) and the RAM array. It replaces the direct SPI-to-RAM connection.

## Interface
- ADDR_SIZE, 8, RAM address width; legal range 1..8; SPI addresses use rx_data[ADDR_SIZE-1:0].
- MEM_DEPTH, 256, RAM depth; informational only, equal to 2**ADDR_SIZE.

Ports:
- clk  in  1  single clock; every register samples on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  10  SPI command word; [9:8] opcode, [7:0] payload.
- rx_valid  in  1  one-cycle strobe qualifying rx_data.
- tx_data  out  8  read data returned to SPI.
- tx_valid  out  1  one-cycle strobe qualifying tx_data.
- host_req  in  1  host access request; held high until host_gnt.
- host_we  in  1  1 = write, 0 = read; stable while host_req is high.
- host_addr  in  ADDR_SIZE  host address; stable while host_req is high.
- host_wdata  in  8  host write data; stable while host_req is high.
- host_gnt  out  1  one-cycle pulse, host access issued to RAM.
- host_rvalid  out  1  one-cycle pulse qualifying host_rdata.
- host_rdata  out  8  host read data.
- mem_en  out  1  RAM enable (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_addr  out  ADDR_SIZE  RAM address (registered).
- mem_wdata  out  8  RAM write data (registered).
- mem_rdata  in  8  RAM read data; valid the cycle after mem_en with mem_we=0.
- spi_overrun  out  1  one-cycle pulse, SPI access command dropped.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- SPI decode on rx_valid:
  - Opcode 00 loads wr_addr; opcode 10 loads rd_addr. Neither command touches the RAM.
  - Opcode 01 sets spi_pend as a write, with addr = wr_addr and data = rx_data[7:0].
  - Opcode 11 sets spi_pend as a read, with addr = rd_addr. Its payload is ignored.
  - The pending slot captures its address at set time. A later 00 or 10 does not alter an already-pending access.
- Overrun: an access command (01/11) that arrives while spi_pend is set and is not being granted that cycle is dropped. spi_overrun pulses in the following cycle.
- Grant and new access in the same cycle: the grant clears the old pending access, and the new command sets spi_pend. Set wins over clear.
- FSM states: IDLE, ISSUE, RDWAIT.
  - In IDLE, if spi_pend or host_req is set, choose a winner. Register mem_en=1 plus mem_we, mem_addr and mem_wdata for the winner, then go to ISSUE.
  - In ISSUE, mem_en is high and host_gnt is high if host won. Next cycle, mem_en returns to 0. A write goes back to IDLE; a read goes to RDWAIT.
  - In RDWAIT, capture mem_rdata into tx_data (SPI) or host_rdata (host). Pulse the matching valid in the next cycle and go back to IDLE.
- Arbitration:
  - If only one requester is pending, it wins.
  - If both are pending, the requester not granted last wins. last_grant resets to host, so SPI wins the first conflict.
  - last_grant updates on every grant.
- tx_data and host_rdata hold their value until the next read for that requester.
- mem_we, mem_addr and mem_wdata hold their last value while mem_en=0.

## Timing
- Reset value of every output and register is 0. This covers tx_*, host_gnt, host_rvalid, host_rdata, mem_*, spi_overrun, busy, wr_addr, rd_addr, spi_pend and the FSM (IDLE). last_grant resets to host.
- Reset asserted mid-operation aborts immediately: the pending access is lost and no valid strobe is produced.
- SPI access, with rx_valid high in cycle 0 and no contention:
  - spi_pend is set in cycle 1 (IDLE decides).
  - mem_en is high in cycle 2.
  - For a read, mem_rdata is valid in cycle 3 and tx_valid is high in cycle 4.
- Host access, with host_req high in cycle 0 while in IDLE:
  - mem_en and host_gnt are high in cycle 1.
  - For a read, host_rvalid is high in cycle 3.
  - The host may drop host_req in the cycle after host_gnt.
- Occupancy: a write holds the port for 2 cycles (IDLE, ISSUE) and a read for 3 cycles. A losing requester waits at most one full access.
- Minimum SPI frame spacing is 12 cycles, which exceeds the worst-case service time of 6 cycles. Overrun therefore only occurs under protocol violation.

## Test plan
- SPI write: send 00_0x12, then 01_0xA5 (rx_valid in cycle 0) -> in cycle 2, mem_en=1, mem_we=1, mem_addr=0x12, mem_wdata=0xA5; no tx_valid.
- SPI read: RAM[0x12]=0xA5; send 10_0x12, then 11_0x00 in cycle 0 -> mem_en=1 with mem_we=0 in cycle 2; tx_valid=1 with tx_data=0xA5 in cycle 4 only.
- Host write then read: host write 0x3C to 0x40, then host read 0x40 -> host_gnt in cycle 1 for each; host_rvalid=1 with host_rdata=0x3C, 3 cycles after the read request.
- Conflict: spi_pend and host_req are set in the same IDLE cycle twice in a row -> the first conflict grants SPI and the second grants host; neither access is lost.
- Overrun: while a host read is in progress, deliver 01_0x11 and then 01_0x22, 1 cycle apart -> spi_overrun pulses once; only 0x22 is written… correction: only 0x11 is written; 0x22 is dropped.
- Reset mid-read: assert rst_n=0 during RDWAIT -> all outputs are 0 immediately, no tx_valid or host_rvalid follows, and busy=0 after release.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_arbiter : SPI command decoder plus round-robin arbiter onto one RAM port
// Rev 1.0
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [7:0]           host_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 spi_overrun,
    output logic                 busy
);

    localparam logic [1:0] c_OP_WR_ADDR = 2'b00;
    localparam logic [1:0] c_OP_RD_ADDR = 2'b10;

    if (MEM_DEPTH != (1 << ADDR_SIZE)) begin : g_depth_check
        $error("ram_arbiter: MEM_DEPTH must equal 2**ADDR_SIZE");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RDWAIT = 2'd2
    } state_t;

    state_t                 r_state;
    logic [ADDR_SIZE-1:0]   r_wr_addr;
    logic [ADDR_SIZE-1:0]   r_rd_addr;
    logic                   r_spi_pend;
    logic                   r_spi_we;
    logic [ADDR_SIZE-1:0]   r_spi_addr;
    logic [7:0]             r_spi_wdata;
    logic                   r_sel_spi;
    logic                   r_last_spi;   // 0 = host granted last (reset value)

    logic                   w_spi_win;
    logic                   w_spi_grant;

    // SPI wins when it is alone or when the host was served last
    assign w_spi_win   = r_spi_pend && (!host_req || !r_last_spi);
    assign w_spi_grant = (r_state == S_IDLE) && w_spi_win;
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_spi_pend  <= 1'b0;
            r_spi_we    <= 1'b0;
            r_spi_addr  <= '0;
            r_spi_wdata <= 8'h00;
            r_sel_spi   <= 1'b0;
            r_last_spi  <= 1'b0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            host_gnt    <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata  <= 8'h00;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 8'h00;
            spi_overrun <= 1'b0;
        end else begin
            host_gnt    <= 1'b0;
            tx_valid    <= 1'b0;
            host_rvalid <= 1'b0;
            spi_overrun <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_spi_pend || host_req) begin
                        mem_en  <= 1'b1;
                        r_state <= S_ISSUE;
                        if (w_spi_win) begin
                            mem_we     <= r_spi_we;
                            mem_addr   <= r_spi_addr;
                            mem_wdata  <= r_spi_wdata;
                            r_spi_pend <= 1'b0;
                            r_sel_spi  <= 1'b1;
                            r_last_spi <= 1'b1;
                        end else begin
                            mem_we     <= host_we;
                            mem_addr   <= host_addr;
                            mem_wdata  <= host_wdata;
                            host_gnt   <= 1'b1;
                            r_sel_spi  <= 1'b0;
                            r_last_spi <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    mem_en  <= 1'b0;
                    r_state <= mem_we ? S_IDLE : S_RDWAIT;
                end
                S_RDWAIT: begin
                    if (r_sel_spi) begin
                        tx_data  <= mem_rdata;
                        tx_valid <= 1'b1;
                    end else begin
                        host_rdata  <= mem_rdata;
                        host_rvalid <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Placed after the FSM so a new access overrides a same-cycle grant clear
            if (rx_valid) begin
                case (rx_data[9:8])
                    c_OP_WR_ADDR: r_wr_addr <= rx_data[ADDR_SIZE-1:0];
                    c_OP_RD_ADDR: r_rd_addr <= rx_data[ADDR_SIZE-1:0];
                    default: begin
                        if (r_spi_pend && !w_spi_grant) begin
                            spi_overrun <= 1'b1;
                        end else begin
                            r_spi_pend <= 1'b1;
                            r_spi_we   <= !rx_data[9];
                            r_spi_addr <= rx_data[9] ? r_rd_addr : r_wr_addr;
                            if (!rx_data[9]) begin
                                r_spi_wdata <= rx_data[7:0];
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
